// File: rtl/divm_sched.sv
// divm_sched: steps one divide-by-M counter through four fixed divisors
// (M0..M3). Each divisor is held for REPS output periods. The sequence is
// started and aborted with level inputs. A tick marks the last cycle of each
// output period.
//
// Handshake: start and stop are plain levels sampled on every rising clk_in
// edge. There is no acknowledge. stop wins over start and over a tick in the
// same cycle. start is ignored while busy. stop is ignored in IDLE and DONE.
//
// Ports:
//   clk_in    system clock, rising edge
//   rstn      asynchronous active-low reset
//   start     begin a sequence from IDLE or DONE
//   stop      abort a running sequence
//   clk_out   divided clock for the current step (high phase = M>>1 cycles)
//   tick      one-cycle pulse in the last cycle of each output period
//   step      index of the divisor in use
//   busy      sequence running
//   done      single pass completed, held until the next start
//   dbg_state FSM state (0 IDLE, 1 RUN, 2 DONE)
module divm_sched #(
  parameter int N    = 16,
  parameter int M0   = 5,
  parameter int M1   = 10,
  parameter int M2   = 3,
  parameter int M3   = 2,
  parameter int REPS = 2,
  parameter int LOOP = 0
) (
  input  logic       clk_in,
  input  logic       rstn,
  input  logic       start,
  input  logic       stop,
  output logic       clk_out,
  output logic       tick,
  output logic [1:0] step,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] REPS_LAST = 8'(REPS - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [7:0]     rep_q, rep_d;
  logic [1:0]     step_q, step_d;
  logic [N-1:0]   m_cur;
  logic [N-1:0]   m_last;
  logic           period_end;

  // Current divisor selected by step
  always_comb begin
    m_cur = N'(M0);
    case (step_q)
      2'd0:    m_cur = N'(M0);
      2'd1:    m_cur = N'(M1);
      2'd2:    m_cur = N'(M2);
      default: m_cur = N'(M3);
    endcase
  end

  assign m_last     = m_cur - N'(1);
  assign period_end = (cnt_q == m_last);

  // State register
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          cnt_d   = '0;
          rep_d   = '0;
          step_d  = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rep_d   = '0;
          step_d  = '0;
        end else if (period_end) begin
          cnt_d = '0;
          if (rep_q < REPS_LAST) begin
            rep_d = rep_q + 8'd1;
          end else begin
            rep_d = '0;
            if (step_q == 2'd3) begin
              // Step 3 wraps to step 0. Without LOOP, the pass ends here.
              step_d = '0;
              if (LOOP == 0) state_d = S_DONE;
            end else begin
              step_d = step_q + 2'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + N'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        rep_d   = '0;
        step_d  = '0;
      end
    endcase
  end

  // Outputs, decoded from registers only. clk_out and tick are gated by busy,
  // so both are quiet outside RUN.
  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    clk_out   = busy && (cnt_q < (m_cur >> 1));
    tick      = busy && period_end;
    step      = step_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_divm_sched.sv
module tb_divm_sched;

  logic       clk_in;
  logic       rstn;
  logic       start, stop;
  logic       clk_out, tick, busy, done;
  logic [1:0] step_o, dbg_state;
  logic       start2, stop2;
  logic       clk_out2, tick2, busy2, done2;
  logic [1:0] step2, dbg_state2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  divm_sched dut (
    .clk_in(clk_in), .rstn(rstn), .start(start), .stop(stop),
    .clk_out(clk_out), .tick(tick), .step(step_o), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  divm_sched #(.REPS(1), .LOOP(1)) dut_loop (
    .clk_in(clk_in), .rstn(rstn), .start(start2), .stop(stop2),
    .clk_out(clk_out2), .tick(tick2), .step(step2), .busy(busy2),
    .done(done2), .dbg_state(dbg_state2)
  );

  // Clock and reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one edge and settle. Outputs are sampled here, and inputs driven
  // here are seen by the following edge.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Expected step for cycle c (1-based) of a default single pass
  function automatic logic [1:0] exp_step_single(int c);
    if (c <= 10) return 2'd0;
    if (c <= 30) return 2'd1;
    if (c <= 36) return 2'd2;
    if (c <= 40) return 2'd3;
    return 2'd0;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    cyc(); cyc();
    total_cnt++;
    if ({busy, done, clk_out, tick, step_o} !== 6'b0) $display("FAIL reset_outs: got %b expected 000000", {busy, done, clk_out, tick, step_o});
    else pass_cnt++;
    #2 rstn = 1'b1;
    cyc();
    total_cnt++;
    if ({busy, done, clk_out, tick, step_o} !== 6'b0) $display("FAIL post_reset_outs: got %b expected 000000", {busy, done, clk_out, tick, step_o});
    else pass_cnt++;
  endtask

  task automatic test_single_pass();
    logic [9:0] duty_exp;
    logic [9:0] duty_got;
    int busy_cycles;
    int ticks;
    logic exp_tick;
    duty_exp    = 10'b1100011000;
    duty_got    = '0;
    busy_cycles = 0;
    ticks       = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      exp_tick = (c == 5 || c == 10 || c == 20 || c == 30 || c == 33 || c == 36 || c == 38 || c == 40);
      if (busy) busy_cycles++;
      if (tick) ticks++;
      if (c <= 10) duty_got[10-c] = clk_out;
      total_cnt++;
      if (busy !== (c <= 40)) $display("FAIL pass_busy c=%0d: got %b expected %b", c, busy, (c <= 40));
      else pass_cnt++;
      total_cnt++;
      if (tick !== exp_tick) $display("FAIL pass_tick c=%0d: got %b expected %b", c, tick, exp_tick);
      else pass_cnt++;
      total_cnt++;
      if (step_o !== exp_step_single(c)) $display("FAIL pass_step c=%0d: got %0d expected %0d", c, step_o, exp_step_single(c));
      else pass_cnt++;
      total_cnt++;
      if (done !== (c >= 41)) $display("FAIL pass_done c=%0d: got %b expected %b", c, done, (c >= 41));
      else pass_cnt++;
      if (c == 11) begin
        total_cnt++;
        if (clk_out !== 1'b1) $display("FAIL step_change_clk c=11: got %b expected 1", clk_out);
        else pass_cnt++;
      end
      if (c == 39 || c == 40) begin
        total_cnt++;
        if (clk_out !== (c == 39)) $display("FAIL duty_m3 c=%0d: got %b expected %b", c, clk_out, (c == 39));
        else pass_cnt++;
      end
      if (c >= 41) begin
        total_cnt++;
        if (clk_out !== 1'b0) $display("FAIL done_clk c=%0d: got %b expected 0", c, clk_out);
        else pass_cnt++;
      end
      // stop while in DONE must be ignored
      stop = (c == 42);
      if (c < 45) cyc();
    end
    stop = 1'b0;
    total_cnt++;
    if (duty_got !== duty_exp) $display("FAIL duty_m0: got %b expected %b", duty_got, duty_exp);
    else pass_cnt++;
    total_cnt++;
    if (busy_cycles !== 40) $display("FAIL busy_len: got %0d expected 40", busy_cycles);
    else pass_cnt++;
    total_cnt++;
    if (ticks !== 8) $display("FAIL tick_count: got %0d expected 8", ticks);
    else pass_cnt++;
  endtask

  task automatic test_stop();
    int guard;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c < 12; c++) cyc();
    total_cnt++;
    if ({busy, step_o} !== 3'b101) $display("FAIL stop_pre: got %b expected 101", {busy, step_o});
    else pass_cnt++;
    start = 1'b1; stop = 1'b1;
    cyc();
    total_cnt++;
    if ({busy, done, clk_out, tick, step_o} !== 6'b0) $display("FAIL stop_idle: got %b expected 000000", {busy, done, clk_out, tick, step_o});
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL stop_priority_idle: got %b expected 0", busy);
    else pass_cnt++;
    start = 1'b0; stop = 1'b0;
    cyc();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL stop_released: got %b expected 0", busy);
    else pass_cnt++;
    start = 1'b1;
    cyc();
    start = 1'b0;
    total_cnt++;
    if ({busy, clk_out, tick, step_o} !== 5'b11000) $display("FAIL restart_first: got %b expected 11000", {busy, clk_out, tick, step_o});
    else pass_cnt++;
    for (int c = 2; c <= 5; c++) cyc();
    total_cnt++;
    if ({busy, tick, step_o} !== 4'b1100) $display("FAIL restart_tick5: got %b expected 1100", {busy, tick, step_o});
    else pass_cnt++;
    guard = 0;
    while (!done && guard < 60) begin
      cyc();
      guard++;
    end
    total_cnt++;
    if (done !== 1'b1) $display("FAIL restart_done: got %b expected 1 (timeout)", done);
    else pass_cnt++;
  endtask

  task automatic test_start_held();
    start = 1'b1;
    cyc();
    total_cnt++;
    if ({busy, done} !== 2'b10) $display("FAIL held_restart: got %b expected 10", {busy, done});
    else pass_cnt++;
    for (int c = 2; c <= 40; c++) begin
      cyc();
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL held_busy c=%0d: got %b expected 1", c, busy);
      else pass_cnt++;
    end
    total_cnt++;
    if (step_o !== 2'd3) $display("FAIL held_last_step: got %0d expected 3", step_o);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if ({busy, done, clk_out} !== 3'b010) $display("FAIL held_done_pulse: got %b expected 010", {busy, done, clk_out});
    else pass_cnt++;
    cyc();
    total_cnt++;
    if ({busy, done, clk_out, step_o} !== 5'b10100) $display("FAIL held_next_pass: got %b expected 10100", {busy, done, clk_out, step_o});
    else pass_cnt++;
    start = 1'b0; stop = 1'b1;
    cyc();
    stop = 1'b0;
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL held_stop: got %b expected 00", {busy, done});
    else pass_cnt++;
  endtask

  task automatic test_loop();
    int p;
    logic [1:0] es;
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      p  = (c - 1) % 20;
      es = (p < 5) ? 2'd0 : (p < 15) ? 2'd1 : (p < 18) ? 2'd2 : 2'd3;
      total_cnt++;
      if ({busy2, done2} !== 2'b10) $display("FAIL loop_busy c=%0d: got %b expected 10", c, {busy2, done2});
      else pass_cnt++;
      total_cnt++;
      if (step2 !== es) $display("FAIL loop_step c=%0d: got %0d expected %0d", c, step2, es);
      else pass_cnt++;
      total_cnt++;
      if (tick2 !== (p == 4 || p == 14 || p == 17 || p == 19)) $display("FAIL loop_tick c=%0d: got %b", c, tick2);
      else pass_cnt++;
      if (p == 0) begin
        total_cnt++;
        if (clk_out2 !== 1'b1) $display("FAIL loop_wrap_clk c=%0d: got %b expected 1", c, clk_out2);
        else pass_cnt++;
      end
      if (c < 100) cyc();
    end
    stop2 = 1'b1;
    cyc();
    stop2 = 1'b0;
    total_cnt++;
    if (busy2 !== 1'b0) $display("FAIL loop_stop: got %b expected 0", busy2);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 2; c <= 33; c++) cyc();
    total_cnt++;
    if ({busy, step_o, tick} !== 4'b1101) $display("FAIL arst_pre: got %b expected 1101", {busy, step_o, tick});
    else pass_cnt++;
    #2 rstn = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, clk_out, tick, step_o} !== 6'b0) $display("FAIL arst_immediate: got %b expected 000000", {busy, done, clk_out, tick, step_o});
    else pass_cnt++;
    cyc();
    #2 rstn = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      total_cnt++;
      if ({busy, done, clk_out, tick} !== 4'b0) $display("FAIL arst_idle c=%0d: got %b expected 0000", c, {busy, done, clk_out, tick});
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_stop();
    test_start_held();
    test_loop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
